// File: rtl/ov7670_capture_px_pkg.sv
// Shared types for the OV7670 pixel capture stage: mode encodings, FSM states
// and the RGB565 pixel layout.
package cam_pkg;

    localparam logic [1:0] MODE_RGB444 = 2'd0;
    localparam logic [1:0] MODE_GRAY4  = 2'd1;
    localparam logic [1:0] MODE_BIN    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Average of the top four bits of each channel; the sum is at most 45, so the
    // quotient always fits in four bits.
    function automatic logic [3:0] gray4(input rgb565_t px);
        logic [5:0] sum;
        sum = {2'b00, px.r[4:1]} + {2'b00, px.g[5:2]} + {2'b00, px.b[4:1]};
        return 4'(sum / 6'd3);
    endfunction

endpackage

// File: rtl/ov7670_capture_px_if.sv
// Frame-buffer write port: address, data and write enable, aligned in the same cycle.
interface ov7670_capture_px_if #(
    parameter int ADDR_W = 17,
    parameter int DOUT_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic [DOUT_W-1:0] dout;
    logic              we;

    modport master (output addr, output dout, output we);
    modport slave  (input  addr, input  dout, input  we);
endinterface

// File: rtl/ov7670_capture_px_convert.sv
// Combinational RGB565 to RGB444 / GRAY4 / inverted-threshold BIN conversion.
module px_convert
    import cam_pkg::*;
(
    input  rgb565_t     px,
    input  logic [1:0]  mode,
    input  logic [3:0]  thresh,
    output logic [11:0] result
);
    logic [3:0] g;

    always_comb begin
        g = gray4(px);
        unique case (mode)
            MODE_GRAY4: result = {8'd0, g};
            MODE_BIN:   result = {11'd0, (g < thresh)};
            // Reserved encoding falls through to RGB444.
            default:    result = {px.r[4:1], px.g[5:2], px.b[4:1]};
        endcase
    end
endmodule

// File: rtl/ov7670_capture_px.sv
// OV7670 byte-pair capture: pairs camera bytes into RGB565, converts each pixel
// and writes it to a bounded linear frame-buffer address with frame/geometry status.
module ov7670_capture_px
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int ADDR_W   = 17,
    parameter int DOUT_W   = 12
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic                href,
    input  logic [7:0]          d,
    input  logic [1:0]          mode,
    input  logic [3:0]          thresh,
    input  logic                arm,
    ov7670_capture_px_if.master wr,
    output logic                busy,
    output logic                frame_done,
    output logic                geom_err
);
    // Counters have headroom past the active size so overruns stay visible.
    localparam int COL_W = $clog2(H_ACTIVE + 2);
    localparam int ROW_W = $clog2(V_ACTIVE + 2);
    localparam logic [COL_W-1:0] H_MAX = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_MAX = ROW_W'(V_ACTIVE);

    state_e            state_q, state_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        thresh_q, thresh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              geom_err_q, geom_err_d;

    logic        href_eff, vs_rise, vs_fall, hr_fall;
    logic [11:0] conv;

    px_convert u_conv (
        .px     (rgb565_t'({hi_q, d})),
        .mode   (mode_q),
        .thresh (thresh_q),
        .result (conv)
    );

    // Line-valid is ignored while the frame is in vertical blanking.
    assign href_eff = href & ~vsync;
    assign vs_rise  = vsync & ~vsync_q;
    assign vs_fall  = ~vsync & vsync_q;
    assign hr_fall  = href_q & ~href_eff;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d      = state_q;
        vsync_d      = vsync;
        href_d       = href_eff;
        phase_d      = phase_q;
        hi_d         = hi_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_cnt_d   = addr_cnt_q;
        mode_d       = mode_q;
        thresh_d     = thresh_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        geom_err_d   = geom_err_q;

        unique case (state_q)
            IDLE: begin
                if (arm) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_d    = ACTIVE;
                    mode_d     = mode;
                    thresh_d   = thresh;
                    addr_cnt_d = '0;
                    col_d      = '0;
                    row_d      = '0;
                    phase_d    = 1'b0;
                    geom_err_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Frame end wins over any pixel completing in this cycle.
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                    if (row_q != V_MAX) geom_err_d = 1'b1;
                end else if (href_eff) begin
                    if (!phase_q) begin
                        hi_d    = d;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q != '1) col_d = col_q + COL_W'(1);
                        if ((col_q < H_MAX) && (row_q < V_MAX)) begin
                            we_d       = 1'b1;
                            addr_d     = addr_cnt_q;
                            dout_d     = DOUT_W'(conv);
                            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                        end else begin
                            geom_err_d = 1'b1;
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                    if (hr_fall) begin
                        col_d = '0;
                        if (row_q != '1) row_d = row_q + ROW_W'(1);
                        // A set phase here means a dangling odd byte.
                        if (phase_q || (col_q != H_MAX)) geom_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = arm ? WAIT_VS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_cnt_q   <= '0;
            mode_q       <= MODE_RGB444;
            thresh_q     <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            geom_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_cnt_q   <= addr_cnt_d;
            mode_q       <= mode_d;
            thresh_q     <= thresh_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            geom_err_q   <= geom_err_d;
        end
    end

    assign wr.addr    = addr_q;
    assign wr.dout    = dout_q;
    assign wr.we      = we_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign geom_err   = geom_err_q;

endmodule

// File: tb/tb_ov7670_capture_px.sv
// Scoreboard bench for ov7670_capture_px with a 4x2 frame geometry.
module tb_ov7670_capture_px;
    import cam_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 17;
    localparam int DW = 12;

    logic       pclk   = 1'b0;
    logic       rst_n  = 1'b0;
    logic       vsync  = 1'b0;
    logic       href   = 1'b0;
    logic       arm    = 1'b0;
    logic [7:0] d      = '0;
    logic [1:0] mode   = '0;
    logic [3:0] thresh = '0;
    logic       busy, frame_done, geom_err;

    ov7670_capture_px_if #(.ADDR_W(AW), .DOUT_W(DW)) wr ();

    ov7670_capture_px #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW),
        .DOUT_W   (DW)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .mode       (mode),
        .thresh     (thresh),
        .arm        (arm),
        .wr         (wr),
        .busy       (busy),
        .frame_done (frame_done),
        .geom_err   (geom_err)
    );

    always #5 pclk = ~pclk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          fd_cnt  = 0;
    int          fd_before;
    int          tb_col  = 0;
    int          tb_row  = 0;
    bit          cap_en  = 1'b1;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_dout_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference conversion working directly on RGB565 bit positions.
    function automatic logic [11:0] model(input logic [1:0] m, input logic [3:0] th,
                                          input logic [15:0] px);
        int r4, g4, b4, gy;
        r4 = int'(px[15:12]);
        g4 = int'(px[10:7]);
        b4 = int'(px[4:1]);
        gy = (r4 + g4 + b4) / 3;
        if (m == 2'd1) return 12'(gy);
        if (m == 2'd2) return (gy < int'(th)) ? 12'd1 : 12'd0;
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

    always @(negedge pclk) begin
        if (rst_n) begin
            if (frame_done) begin
                fd_cnt++;
                check("we_in_done", wr.we, 0);
            end
            if (wr.we) begin
                if (exp_addr_q.size() == 0) begin
                    check("we_unexpected", wr.we, 0);
                end else begin
                    check("addr", wr.addr, exp_addr_q.pop_front());
                    check("dout", wr.dout, exp_dout_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_px(input logic [15:0] px, input logic [11:0] exp);
        if (cap_en && tb_col < H && tb_row < V) begin
            exp_addr_q.push_back(AW'(tb_row * H + tb_col));
            exp_dout_q.push_back(DW'(exp));
        end
        tb_col++;
        href = 1'b1;
        d = px[15:8];
        tick();
        d = px[7:0];
        tick();
    endtask

    task automatic send_mpx(input logic [15:0] px);
        send_px(px, model(mode, thresh, px));
    endtask

    task automatic end_line();
        href = 1'b0;
        tick();
        tick();
        tb_col = 0;
        tb_row++;
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [3:0] th);
        mode = m;
        thresh = th;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        tb_col = 0;
        tb_row = 0;
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #1;
        check("rst_addr", wr.addr, 0);
        check("rst_dout", wr.dout, 0);
        check("rst_we", wr.we, 0);
        check("rst_busy", busy, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_gerr", geom_err, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        arm = 1'b1;
        tick();

        // RGB444 frame with the red-only pixel first.
        fd_before = fd_cnt;
        start_frame(MODE_RGB444, 4'd0);
        check("busy_active", busy, 1);
        send_px(16'hF800, 12'hF00);
        send_px(16'h07E0, 12'h0F0);
        send_px(16'h001F, 12'h00F);
        send_px(16'hFFFF, 12'hFFF);
        end_line();
        send_mpx(16'h1234);
        send_mpx(16'hABCD);
        send_mpx(16'h8410);
        send_mpx(16'h0000);
        end_line();
        end_frame();
        check("f1_done_cnt", fd_cnt, fd_before + 1);
        check("f1_gerr", geom_err, 0);
        check("f1_busy_end", busy, 0);

        // BIN with thresh 7, then thresh 0.
        for (int t = 0; t < 2; t++) begin
            start_frame(MODE_BIN, (t == 0) ? 4'd7 : 4'd0);
            for (int l = 0; l < V; l++) begin
                for (int p = 0; p < H; p++) begin
                    if (p % 2 == 0) send_px(16'h0000, (t == 0) ? 12'h001 : 12'h000);
                    else            send_px(16'hFFFF, 12'h000);
                end
                end_line();
            end
            end_frame();
            check("bin_gerr", geom_err, 0);
        end

        // GRAY4 extremes and mid-scale.
        start_frame(MODE_GRAY4, 4'd0);
        send_px(16'hFFFF, 12'd15);
        send_px(16'h8410, 12'd8);
        send_px(16'h0000, 12'd0);
        send_mpx(16'h5A5A);
        end_line();
        for (int p = 0; p < H; p++) send_mpx(16'(p * 16'h2345));
        end_line();
        end_frame();
        check("gray_gerr", geom_err, 0);

        // Overlong line: 10 bytes, only 4 written.
        start_frame(MODE_RGB444, 4'd0);
        for (int p = 0; p < 5; p++) send_mpx(16'(16'h1111 * (p + 1)));
        end_line();
        for (int p = 0; p < H; p++) send_mpx(16'(16'h0F0F + p));
        end_line();
        end_frame();
        check("long_gerr", geom_err, 1);
        start_frame(MODE_RGB444, 4'd0);
        check("gerr_cleared", geom_err, 0);
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) send_mpx(16'(16'h3C3C ^ (l * 8 + p)));
            end_line();
        end
        arm = 1'b0;
        end_frame();
        check("short_ok_gerr", geom_err, 0);

        // Single-shot: arm pulsed once, two frames driven, only the first captured.
        fd_before = fd_cnt;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        start_frame(MODE_GRAY4, 4'd0);
        check("ss_busy_a", busy, 1);
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) send_mpx(16'(16'hC0DE + l * 4 + p));
            end_line();
        end
        end_frame();
        cap_en = 1'b0;
        start_frame(MODE_GRAY4, 4'd0);
        check("ss_busy_b", busy, 0);
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) send_mpx(16'hFFFF);
            end_line();
        end
        end_frame();
        check("ss_done_cnt", fd_cnt, fd_before + 1);
        cap_en = 1'b1;

        // Reset mid-line, then a clean frame from address 0.
        arm = 1'b1;
        start_frame(MODE_RGB444, 4'd0);
        send_mpx(16'hF800);
        send_mpx(16'h07E0);
        check("pre_rst_we", wr.we, 1);
        check("pre_rst_busy", busy, 1);
        fd_before = fd_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_we_async", wr.we, 0);
        check("rst_busy_async", busy, 0);
        check("rst_addr_async", wr.addr, 0);
        exp_addr_q.delete();
        exp_dout_q.delete();
        href = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_no_done", fd_cnt, fd_before);
        start_frame(MODE_RGB444, 4'd0);
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) send_mpx(16'(16'h9182 + l * 16 + p));
            end_line();
        end
        end_frame();
        check("post_rst_done", fd_cnt, fd_before + 1);
        check("post_rst_gerr", geom_err, 0);

        check("sb_left", exp_addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
